// File: rtl/instr_encoder_if.sv
// Streaming bundle between a request producer and the RV32I instruction encoder.
// The master drives decoded fields and consumes encoded words; the slave is the encoder.
interface instr_encoder_if #(
  parameter int AW  = 32,
  parameter int ECW = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [3:0]     kind;
  logic [2:0]     funct3;
  logic           f7b;
  logic [4:0]     rd;
  logic [4:0]     rs1;
  logic [4:0]     rs2;
  logic [31:0]    imm;
  logic           out_valid;
  logic           out_ready;
  logic [31:0]    instr;
  logic [AW-1:0]  addr;
  logic           err;
  logic [ECW-1:0] err_cnt;

  modport master (
    output in_valid, kind, funct3, f7b, rd, rs1, rs2, imm, out_ready,
    input  in_ready, out_valid, instr, addr, err, err_cnt
  );

  modport slave (
    input  in_valid, kind, funct3, f7b, rd, rs1, rs2, imm, out_ready,
    output in_ready, out_valid, instr, addr, err, err_cnt
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word and streams it
// out through a single output register, tagging each word with a running byte address.
// Requests whose immediate cannot be represented are consumed, flagged and counted.
module instr_encoder #(
  parameter int            AW        = 32,
  parameter logic [AW-1:0] BASE_ADDR = '0,
  parameter int            ECW       = 8
) (
  input logic            clk,
  input logic            rst,
  input logic            clr,
  instr_encoder_if.slave bus
);

  typedef enum logic [3:0] {
    K_R     = 4'd0,
    K_I     = 4'd1,
    K_LOAD  = 4'd2,
    K_JALR  = 4'd3,
    K_S     = 4'd4,
    K_B     = 4'd5,
    K_LUI   = 4'd6,
    K_AUIPC = 4'd7,
    K_JAL   = 4'd8
  } kind_t;

  logic [31:0]    imm;
  logic [31:0]    word;
  logic           legal;
  logic           fits12;
  logic           fits13;
  logic           fits21;
  logic           in_ready;
  logic           accept;
  logic           drain;
  logic           out_valid_q;
  logic [31:0]    instr_q;
  logic [AW-1:0]  addr_q;
  logic           err_q;
  logic [ECW-1:0] cnt_q;

  assign imm    = bus.imm;
  assign fits12 = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign fits13 = (imm[31:12] == '0) || (imm[31:12] == '1);
  assign fits21 = (imm[31:20] == '0) || (imm[31:20] == '1);

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  assign drain    = out_valid_q && bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.instr     = instr_q;
  assign bus.addr      = addr_q;
  assign bus.err       = err_q;
  assign bus.err_cnt   = cnt_q;

  // Pack the fields for the requested format and decide whether the immediate is encodable.
  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (bus.kind)
      K_R: begin
        word  = {1'b0, bus.f7b, 5'b0, bus.rs2, bus.rs1, bus.funct3, bus.rd, 7'b0110011};
        legal = 1'b1;
      end
      K_I: begin
        if (bus.funct3 == 3'd1 || bus.funct3 == 3'd5) begin
          word  = {1'b0, bus.f7b, 5'b0, imm[4:0], bus.rs1, bus.funct3, bus.rd, 7'b0010011};
          legal = (imm[31:5] == '0);
        end else begin
          word  = {imm[11:0], bus.rs1, bus.funct3, bus.rd, 7'b0010011};
          legal = fits12;
        end
      end
      K_LOAD: begin
        word  = {imm[11:0], bus.rs1, bus.funct3, bus.rd, 7'b0000011};
        legal = fits12;
      end
      K_JALR: begin
        word  = {imm[11:0], bus.rs1, 3'b000, bus.rd, 7'b1100111};
        legal = fits12;
      end
      K_S: begin
        word  = {imm[11:5], bus.rs2, bus.rs1, bus.funct3, imm[4:0], 7'b0100011};
        legal = fits12;
      end
      K_B: begin
        word  = {imm[12], imm[10:5], bus.rs2, bus.rs1, bus.funct3, imm[4:1], imm[11], 7'b1100011};
        legal = fits13 && !imm[0];
      end
      K_LUI: begin
        word  = {imm[31:12], bus.rd, 7'b0110111};
        legal = (imm[11:0] == '0);
      end
      K_AUIPC: begin
        word  = {imm[31:12], bus.rd, 7'b0010111};
        legal = (imm[11:0] == '0);
      end
      K_JAL: begin
        word  = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd, 7'b1101111};
        legal = fits21 && !imm[0];
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

  // Output register, address counter and error bookkeeping; reset beats clear, clear beats increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      addr_q      <= BASE_ADDR;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (accept && legal) begin
        out_valid_q <= 1'b1;
        instr_q     <= word;
      end else if (drain) begin
        out_valid_q <= 1'b0;
      end
      if (clr) begin
        addr_q <= BASE_ADDR;
      end else if (drain) begin
        addr_q <= addr_q + AW'(4);
      end
      err_q <= accept && !legal;
      if (accept && !legal && cnt_q != '1) begin
        cnt_q <= cnt_q + ECW'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors with known words, stall,
// illegal and saturation sequences, then randomized traffic checked by decoding each
// emitted word back into its fields against a queue-free single-slot reference model.
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'h0;

  typedef struct {
    logic [3:0]  kind;
    logic [2:0]  f3;
    logic        f7b;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    bit          hasWord;
    logic [31:0] word;
  } req_t;

  logic clk;
  logic rst;
  logic clr;

  instr_encoder_if #(.AW(32), .ECW(8)) bus ();

  instr_encoder #(.AW(32), .BASE_ADDR(BASE), .ECW(8)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  int totalChecks = 0;
  int badChecks   = 0;

  bit          mValid;
  req_t        mReq;
  logic [31:0] mAddr;
  bit          mErr;
  int          mCnt;
  bit          mInstrZero;

  logic [6:0] opcTable [0:8];
  int         bnd [14];

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic req_t mk(input int kind, input int f3, input bit f7b, input int rd,
                              input int rs1, input int rs2, input logic [31:0] imm,
                              input bit hasWord, input logic [31:0] word);
    req_t r;
    r.kind = 4'(kind); r.f3 = 3'(f3); r.f7b = f7b;
    r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2);
    r.imm = imm; r.hasWord = hasWord; r.word = word;
    return r;
  endfunction

  function automatic bit isShift(input req_t r);
    return (r.kind == 4'd1) && (r.f3 == 3'd1 || r.f3 == 3'd5);
  endfunction

  // Legality from the numeric ranges of each format.
  function automatic bit legalOf(input req_t r);
    int s;
    s = r.imm;
    if (isShift(r)) return r.imm < 32;
    case (r.kind)
      4'd0:             return 1'b1;
      4'd1, 4'd2, 4'd3, 4'd4: return (s >= -2048) && (s <= 2047);
      4'd5:             return (s >= -4096) && (s <= 4094) && (s % 2 == 0);
      4'd6, 4'd7:       return (s % 4096 == 0);
      4'd8:             return (s >= -(1 << 20)) && (s <= (1 << 20) - 2) && (s % 2 == 0);
      default:          return 1'b0;
    endcase
  endfunction

  // Decode an emitted word and compare its fields with the request that produced it.
  task automatic checkWord(input req_t r, input logic [31:0] w);
    int sw, immI, immS, immB, immJ;
    sw   = w;
    immI = sw >>> 20;
    immS = (sw >>> 25) * 32 + int'(w[11:7]);
    immB = (sw >>> 31) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
    immJ = (sw >>> 31) * (1 << 20) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
    if (r.hasWord) checkOutput("word", w, r.word);
    checkOutput("opcode", 32'(w[6:0]), 32'(opcTable[r.kind]));
    if (r.kind == 4'd0 || isShift(r)) begin
      checkOutput("rd", 32'(w[11:7]), 32'(r.rd));
      checkOutput("rs1", 32'(w[19:15]), 32'(r.rs1));
      checkOutput("f3", 32'(w[14:12]), 32'(r.f3));
      checkOutput("f7b", 32'(w[30]), 32'(r.f7b));
      checkOutput("zeros", 32'({w[31], w[29:25]}), 32'h0);
      if (r.kind == 4'd0) checkOutput("rs2", 32'(w[24:20]), 32'(r.rs2));
      else                checkOutput("shamt", 32'(w[24:20]), 32'(r.imm[4:0]));
    end else begin
      case (r.kind)
        4'd1, 4'd2, 4'd3: begin
          checkOutput("rd", 32'(w[11:7]), 32'(r.rd));
          checkOutput("rs1", 32'(w[19:15]), 32'(r.rs1));
          checkOutput("f3", 32'(w[14:12]), (r.kind == 4'd3) ? 32'h0 : 32'(r.f3));
          checkOutput("imm", immI, r.imm);
        end
        4'd4, 4'd5: begin
          checkOutput("rs1", 32'(w[19:15]), 32'(r.rs1));
          checkOutput("rs2", 32'(w[24:20]), 32'(r.rs2));
          checkOutput("f3", 32'(w[14:12]), 32'(r.f3));
          checkOutput("imm", (r.kind == 4'd4) ? immS : immB, r.imm);
        end
        4'd6, 4'd7: begin
          checkOutput("rd", 32'(w[11:7]), 32'(r.rd));
          checkOutput("imm", w & 32'hFFFF_F000, r.imm);
        end
        default: begin
          checkOutput("rd", 32'(w[11:7]), 32'(r.rd));
          checkOutput("imm", immJ, r.imm);
        end
      endcase
    end
  endtask

  task automatic modelReset();
    mValid = 1'b0; mAddr = BASE; mErr = 1'b0; mCnt = 0; mInstrZero = 1'b1;
  endtask

  // One clock cycle: drive inputs, check the visible state, then advance the model.
  task automatic applyStimulus(input bit v, input req_t r, input bit ordy, input bit c,
                               input bit rs, output bit accepted);
    bit rdy, acc, ofire, lg;
    @(negedge clk);
    bus.in_valid = v; bus.kind = r.kind; bus.funct3 = r.f3; bus.f7b = r.f7b;
    bus.rd = r.rd; bus.rs1 = r.rs1; bus.rs2 = r.rs2; bus.imm = r.imm;
    bus.out_ready = ordy; clr = c; rst = rs;
    #1;
    rdy = !mValid || ordy;
    checkOutput("out_valid", 32'(bus.out_valid), 32'(mValid));
    checkOutput("in_ready", 32'(bus.in_ready), 32'(rdy));
    checkOutput("addr", bus.addr, mAddr);
    checkOutput("err", 32'(bus.err), 32'(mErr));
    checkOutput("err_cnt", 32'(bus.err_cnt), mCnt);
    if (mValid) checkWord(mReq, bus.instr);
    else if (mInstrZero) checkOutput("instr_reset", bus.instr, 32'h0);
    acc   = v && rdy;
    ofire = mValid && ordy;
    lg    = legalOf(r);
    accepted = acc;
    if (rs) begin
      modelReset();
    end else begin
      if (c) mAddr = BASE;
      else if (ofire) mAddr = mAddr + 32'd4;
      if (acc && lg) begin
        mValid = 1'b1; mReq = r; mInstrZero = 1'b0;
      end else if (ofire) begin
        mValid = 1'b0;
      end
      mErr = acc && !lg;
      if (acc && !lg && mCnt < 255) mCnt++;
    end
  endtask

  task automatic sendReq(input req_t r);
    bit a;
    int n;
    a = 1'b0;
    n = 0;
    while (!a && n < 20) begin
      applyStimulus(1'b1, r, 1'b1, 1'b0, 1'b0, a);
      n++;
    end
    if (!a) checkOutput("accept_timeout", 32'h0, 32'h1);
  endtask

  task automatic idle(input int n);
    bit a;
    req_t z;
    z = mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, z, 1'b1, 1'b0, 1'b0, a);
  endtask

  function automatic req_t makeRandom();
    req_t r;
    int sel;
    r = mk($urandom_range(0, 10), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
           $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), 32'h0, 0, 32'h0);
    sel = $urandom_range(0, 3);
    if (sel == 0) r.imm = $urandom;
    else if (sel == 1) r.imm = bnd[$urandom_range(0, 13)];
    else if (isShift(r)) r.imm = $urandom_range(0, 31);
    else if (r.kind == 4'd5) r.imm = (int'($urandom_range(0, 4095)) - 2048) * 2;
    else if (r.kind == 4'd8) r.imm = (int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19)) * 2;
    else if (r.kind == 4'd6 || r.kind == 4'd7) r.imm = $urandom & 32'hFFFF_F000;
    else r.imm = int'($urandom_range(0, 4095)) - 2048;
    return r;
  endfunction

  // Directed scenarios followed by randomized traffic.
  initial begin
    bit a;
    req_t r;
    opcTable = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    bnd = '{2047, -2048, 2048, -2049, 4094, -4096, 4095, 4096,
            32'h000F_FFFE, -(1 << 20), (1 << 20), 31, 32, -1};
    rst = 1'b1; clr = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.kind = '0; bus.funct3 = '0; bus.f7b = 1'b0;
    bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0; bus.imm = '0;
    modelReset();
    repeat (2) @(posedge clk);

    idle(1);
    sendReq(mk(1, 0, 0, 1, 0, 0, 32'd5, 1, 32'h0050_0093));
    sendReq(mk(0, 0, 1, 3, 1, 2, 32'd0, 1, 32'h4020_81B3));
    sendReq(mk(1, 5, 1, 1, 1, 0, 32'd3, 1, 32'h4030_D093));
    sendReq(mk(5, 0, 0, 0, 0, 0, -32'sd4, 1, 32'hFE00_0EE3));
    sendReq(mk(6, 0, 0, 5, 0, 0, 32'h1234_5000, 1, 32'h1234_52B7));
    idle(2);

    sendReq(mk(2, 2, 0, 7, 8, 0, 32'd100, 0, 32'h0));
    r = mk(4, 2, 0, 0, 9, 10, -32'sd8, 0, 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, r, 1'b0, 1'b0, 1'b0, a);
    sendReq(r);
    sendReq(mk(8, 0, 0, 1, 0, 0, -32'sd2048, 0, 32'h0));
    sendReq(mk(3, 7, 0, 1, 2, 0, 32'd2047, 0, 32'h0));
    idle(2);

    sendReq(mk(1, 0, 0, 1, 0, 0, 32'd2048, 0, 32'h0));
    sendReq(mk(8, 0, 0, 1, 0, 0, 32'd3, 0, 32'h0));
    idle(2);
    checkOutput("err_cnt_two", 32'(bus.err_cnt), 32'd2);

    r = mk(15, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    for (int i = 0; i < 260; i++) sendReq(r);
    idle(2);
    checkOutput("err_cnt_sat", 32'(bus.err_cnt), 32'd255);

    sendReq(mk(7, 0, 0, 4, 0, 0, 32'hABCD_E000, 0, 32'h0));
    applyStimulus(1'b0, r, 1'b1, 1'b1, 1'b0, a);
    idle(1);
    sendReq(mk(0, 7, 0, 2, 3, 4, 32'h0, 0, 32'h0));
    applyStimulus(1'b0, r, 1'b0, 1'b0, 1'b1, a);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, makeRandom(), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 24) == 0, $urandom_range(0, 299) == 0, a);
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
